// File: rtl/line_send_sched.sv
// Line send scheduler: one trig per enabled camera per row, spaced by TICK cycles, rows wrap at V_ACT.
// Optional WAIT_DONE timeout is built in when LINE_SEND_SCHED_TIMEOUT_EN is defined.
module line_send_sched #(
    parameter int N_CAM   = 2,
    parameter int V_ACT   = 720,
    parameter int TICK    = 125_000,
    parameter int TIMEOUT = 250_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_CAM-1:0] cam_mask,
    input  logic             tx_done,
    output logic             trig,
    output logic [15:0]      index,
    output logic [2:0]       cam_id,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);
    localparam int CNT_MAX = (TICK > TIMEOUT) ? TICK : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, TRIG, WAIT_DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [9:0]       row_reg;
    logic [2:0]       cam_ptr_reg;
    logic [N_CAM-1:0] shadow_reg;

    logic [N_CAM-1:0] eff_mask;
    logic [2:0]       sel;
    logic [2:0]       nxt;
    logic             nxt_found;
    logic             to_hit;
    logic             advance;

    generate
        if (N_CAM < 2 || N_CAM > 8 || V_ACT < 1 || V_ACT > 1024 || TICK < 2) begin : g_bad_param
            $error("line_send_sched: parameter out of range");
        end
    endgenerate

    // An empty shadow (row started with no camera enabled) falls back to the live mask.
    always_comb begin
        eff_mask  = (shadow_reg == '0) ? cam_mask : shadow_reg;
        sel       = '0;
        nxt       = '0;
        nxt_found = 1'b0;
        for (int i = N_CAM - 1; i >= 0; i--) begin
            if (eff_mask[i] && i >= int'(cam_ptr_reg)) begin
                sel = 3'(i);
            end
            if (shadow_reg[i] && i > int'(cam_id)) begin
                nxt       = 3'(i);
                nxt_found = 1'b1;
            end
        end
    end

`ifdef LINE_SEND_SCHED_TIMEOUT_EN
    assign to_hit = (cnt_reg == CW'(TIMEOUT - 1));
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign advance = (state_reg == WAIT_DONE) && (tx_done || to_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            row_reg     <= '0;
            cam_ptr_reg <= '0;
            shadow_reg  <= '0;
            trig        <= 1'b0;
            index       <= '0;
            cam_id      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef LINE_SEND_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            trig       <= 1'b0;
            frame_done <= 1'b0;
`ifdef LINE_SEND_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg  <= WAIT_TICK;
                        cnt_reg    <= '0;
                        shadow_reg <= cam_mask;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        row_reg     <= '0;
                        cam_ptr_reg <= '0;
                    end else begin
                        if (shadow_reg == '0) begin
                            shadow_reg <= cam_mask;
                        end
                        if (cnt_reg == CW'(TICK - 1)) begin
                            if (eff_mask != '0) begin
                                state_reg <= TRIG;
                                cnt_reg   <= '0;
                                trig      <= 1'b1;
                                busy      <= 1'b1;
                                cam_id    <= sel;
                                index     <= {3'b000, sel, row_reg};
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                TRIG: begin
                    state_reg <= WAIT_DONE;
                    cnt_reg   <= cnt_reg + 1'b1;
                end
                WAIT_DONE: begin
                    if (advance) begin
                        busy    <= 1'b0;
                        cnt_reg <= '0;
`ifdef LINE_SEND_SCHED_TIMEOUT_EN
                        timeout_err <= !tx_done;
`endif
                        if (nxt_found) begin
                            cam_ptr_reg <= nxt;
                        end else begin
                            cam_ptr_reg <= '0;
                            shadow_reg  <= cam_mask;
                            if (row_reg == 10'(V_ACT - 1)) begin
                                row_reg    <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end
                        // Disabled mid-line: the line is finished first, then position is dropped.
                        if (enable) begin
                            state_reg <= WAIT_TICK;
                        end else begin
                            state_reg   <= IDLE;
                            row_reg     <= '0;
                            cam_ptr_reg <= '0;
                        end
                    end
`ifdef LINE_SEND_SCHED_TIMEOUT_EN
                    else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_send_sched.sv
// Bench for line_send_sched: directed phases plus randomized transactions against a row/camera model.
module tb_line_send_sched;
    localparam int NC = 2;
    localparam int VA = 3;
    localparam int TK = 4;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NC-1:0] cam_mask;
    logic          tx_done;
    logic          trig;
    logic [15:0]   index;
    logic [2:0]    cam_id;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_seen  = 0;
    int to_seen  = 0;
    int fd_exp   = 0;
    int to_exp   = 0;

    int            m_row;
    int            m_cam;
    logic [NC-1:0] m_shadow;
    logic [15:0]   seq_tab [7];

    line_send_sched #(.N_CAM(NC), .V_ACT(VA), .TICK(TK), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cam_mask(cam_mask), .tx_done(tx_done),
        .trig(trig), .index(index), .cam_id(cam_id), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen <= fd_seen + 1;
        if (timeout_err === 1'b1) to_seen <= to_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_from(input logic [NC-1:0] m, input int from);
        for (int i = from; i < NC; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [NC-1:0] rand_mask();
        logic [NC-1:0] v;
        v = '0;
        while (v == '0) v = NC'($urandom);
        return v;
    endfunction

    function automatic logic [15:0] exp_index();
        return {6'(m_cam), 10'(m_row)};
    endfunction

    task automatic m_restart(input logic [NC-1:0] mk);
        m_row    = 0;
        m_shadow = mk;
        m_cam    = lowest_from(mk, 0);
    endtask

    task automatic m_advance(input logic [NC-1:0] mk, output bit wrap);
        int n;
        n    = lowest_from(m_shadow, m_cam + 1);
        wrap = 1'b0;
        if (n >= 0) begin
            m_cam = n;
        end else begin
            m_row    = (m_row + 1) % VA;
            wrap     = (m_row == 0);
            m_shadow = mk;
            m_cam    = lowest_from(mk, 0);
            if (wrap) fd_exp++;
        end
    endtask

    task automatic chk_trig();
        chk("trig", trig, 1);
        chk("index", index, exp_index());
        chk("cam_id", cam_id, m_cam);
        chk("busy_at_trig", busy, 1);
    endtask

    task automatic next_trig();
        int n;
        n = 0;
        while (trig !== 1'b1 && n < TK + 5) begin
            step();
            n++;
        end
        chk("trig_seen", trig, 1);
        chk("trig_gap", n, TK);
    endtask

    task automatic txn(input int d, input bit mid);
        bit wrap;
        chk_trig();
        if (mid) cam_mask = rand_mask();
        repeat (d) step();
        tx_done = 1'b1;
        m_advance(cam_mask, wrap);
        step();
        tx_done = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("frame_done", frame_done, wrap);
    endtask

    initial begin
        int  cnt_t;
        int  fd0;
        int  to0;
        bit  wrap;
        seq_tab[0] = 16'h0000; seq_tab[1] = 16'h0400; seq_tab[2] = 16'h0001;
        seq_tab[3] = 16'h0401; seq_tab[4] = 16'h0002; seq_tab[5] = 16'h0402;
        seq_tab[6] = 16'h0000;

        rst = 1'b1; enable = 1'b0; cam_mask = '0; tx_done = 1'b0;
        step(); step();
        chk("rst_trig", trig, 0);
        chk("rst_index", index, 0);
        chk("rst_cam_id", cam_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        step();

        // Full frame with both cameras, tx_done two cycles after trig
        cam_mask = 2'b11; enable = 1'b1; m_restart(2'b11);
        step();
        next_trig();
        for (int k = 0; k < 7; k++) begin
            chk("seq_table", index, seq_tab[k]);
            txn(2, 1'b0);
            next_trig();
        end

        // Only camera 1 enabled
        cam_mask = 2'b10;
        txn(3, 1'b0);
        next_trig();
        for (int k = 0; k < 4; k++) begin
            chk("mask10_cam", cam_id, 1);
            txn($urandom_range(1, 5), 1'b0);
            next_trig();
        end

        // Random masks and completion delays
        for (int k = 0; k < 20; k++) begin
            txn($urandom_range(1, 5), 1'($urandom_range(0, 1)));
            next_trig();
        end

        // No tx_done after trig
        chk_trig();
`ifdef LINE_SEND_SCHED_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("pre_timeout_err", timeout_err, 0);
        chk("pre_timeout_busy", busy, 1);
        m_advance(cam_mask, wrap);
        step();
        to_exp++;
        chk("timeout_err", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_frame_done", frame_done, wrap);
`else
        repeat (30) step();
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_err", timeout_err, 0);
        tx_done = 1'b1;
        m_advance(cam_mask, wrap);
        step();
        tx_done = 1'b0;
        chk("late_done_busy", busy, 0);
        chk("late_done_frame_done", frame_done, wrap);
`endif
        next_trig();

        // Enable dropped while a line is in flight
        chk_trig();
        step();
        enable = 1'b0;
        step();
        tx_done = 1'b1;
        m_advance(cam_mask, wrap);
        step();
        tx_done = 1'b0;
        chk("disable_busy", busy, 0);
        chk("disable_frame_done", frame_done, wrap);
        cnt_t = 0;
        repeat (20) begin
            step();
            if (trig === 1'b1) cnt_t++;
        end
        chk("idle_no_trig", cnt_t, 0);
        cam_mask = 2'b10; enable = 1'b1; m_restart(2'b10);
        step();
        next_trig();
        chk("restart_index", index, 16'h0400);

        // Empty mask holds the scheduler, first set bit fires next cycle
        txn(2, 1'b0);
        enable = 1'b0;
        step();
        cam_mask = '0; enable = 1'b1;
        step();
        cnt_t = 0;
        repeat (100) begin
            step();
            if (trig === 1'b1) cnt_t++;
        end
        chk("mask0_no_trig", cnt_t, 0);
        cam_mask = 2'b01; m_restart(2'b01);
        step();
        chk_trig();

        // Asynchronous reset while busy
        step();
        chk("busy_before_rst", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_trig", trig, 0);
        chk("arst_index", index, 0);
        chk("arst_cam_id", cam_id, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_timeout_err", timeout_err, 0);
        enable = 1'b0;
        step(); step();
        rst = 1'b0;
        fd0 = fd_seen; to0 = to_seen;
        cnt_t = 0;
        repeat (30) begin
            step();
            if (trig === 1'b1) cnt_t++;
        end
        chk("post_rst_no_trig", cnt_t, 0);
        chk("post_rst_no_frame_done", fd_seen, fd0);
        chk("post_rst_no_timeout", to_seen, to0);

        chk("frame_done_total", fd_seen, fd_exp);
        chk("timeout_total", to_seen, to_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
